// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: issues FIFO reads, captures the registered read data
// into a 2-entry buffer and presents it in order on a valid/ready stream.
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   output logic                  fifo_cs,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic                  busy
);

   logic [1:0]            occ_q, occ_d;
   logic                  infl_q, infl_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [1:0]            pend;
   logic                  pop;
   logic                  push;

   assign pend = occ_q + {1'b0, infl_q};
   assign pop  = m_valid & m_ready;
   assign push = infl_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q  <= '0;
         infl_q <= 1'b0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         occ_q  <= occ_d;
         infl_q <= infl_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // A slot freed by this cycle's pop may be reclaimed by a new read.
   always_comb begin
      fifo_rd_en = rst_n & en & ~fifo_empty &
                   ((pend < 2'd2) | ((pend == 2'd2) & pop));
   end

   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      infl_d = fifo_rd_en;
      cnt_d  = pop ? cnt_q + 1'b1 : cnt_q;
      case ({push, pop})
         2'b01: begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b10: begin
            if (occ_q == 2'd0) head_d = fifo_data_out;
            else               tail_d = fifo_data_out;
            occ_d = occ_q + 2'd1;
         end
         2'b11: begin
            // Captured word lands behind whatever remains after the pop.
            if (occ_q == 2'd1) begin
               head_d = fifo_data_out;
            end else begin
               head_d = tail_q;
               tail_d = fifo_data_out;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      fifo_cs  = en;
      m_valid  = (occ_q != 2'd0);
      m_data   = head_q;
      rd_count = cnt_q;
      busy     = (occ_q != 2'd0) | infl_q;
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a small registered-read FIFO model.
module tb_fifo_stream_reader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        m_ready = 1'b0;
   logic        fifo_cs, fifo_rd_en, fifo_empty, m_valid, busy;
   logic [31:0] fdo = '0;
   logic [31:0] m_data;
   logic [15:0] rd_count;

   logic        en2 = 1'b0;
   logic        cs2, rd2, mv2, busy2;
   logic [31:0] md2;
   logic [2:0]  cnt2;

   int total = 0, bad = 0;
   int rp = 0, wp = 0;
   int rdcnt = 0, ng = 0;
   logic [31:0] mem [64];
   logic [31:0] got [64];

   always #5 clk = ~clk;

   fifo_stream_reader #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .fifo_cs(fifo_cs), .fifo_rd_en(fifo_rd_en),
      .fifo_data_out(fdo), .fifo_empty(fifo_empty), .m_valid(m_valid), .m_data(m_data),
      .m_ready(m_ready), .rd_count(rd_count), .busy(busy));

   fifo_stream_reader #(.DATA_WIDTH(32), .CNT_WIDTH(3)) dut_w (
      .clk(clk), .rst_n(rst_n), .en(en2), .fifo_cs(cs2), .fifo_rd_en(rd2),
      .fifo_data_out(32'h5), .fifo_empty(1'b0), .m_valid(mv2), .m_data(md2),
      .m_ready(1'b1), .rd_count(cnt2), .busy(busy2));

   assign fifo_empty = (rp == wp);

   // FIFO model: data_out registered on an accepted read.
   always @(posedge clk) begin
      if (fifo_rd_en && rp != wp) begin
         fdo <= mem[rp];
         rp  <= rp + 1;
      end
   end

   always @(posedge clk) begin
      if (fifo_rd_en) rdcnt++;
      if (m_valid && m_ready) begin
         got[ng] = m_data;
         ng++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] v);
      mem[wp] = v;
      wp++;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   int b, r0;

   initial begin
      // reset state
      en = 1'b1;
      cyc(2);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_cnt", rd_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rden", fifo_rd_en, 0);
      chk("rst_cs", fifo_cs, 1);
      en = 1'b0;
      chk("cs_follows_en", fifo_cs, 0);
      rst_n = 1'b1;
      cyc(2);

      // basic order and latency
      push(1); push(10); push(100);
      b = ng; r0 = rdcnt;
      en = 1'b1; m_ready = 1'b1;
      #1 chk("basic_rden0", fifo_rd_en, 1);
      cyc(1);
      chk("basic_v_t1", m_valid, 0);
      chk("basic_busy_t1", busy, 1);
      cyc(1);
      chk("basic_v_t2", m_valid, 1);
      chk("basic_d_t2", m_data, 1);
      cyc(1);
      chk("basic_d_t3", m_data, 10);
      chk("basic_rden_empty", fifo_rd_en, 0);
      cyc(1);
      chk("basic_d_t4", m_data, 100);
      cyc(1);
      chk("basic_v_end", m_valid, 0);
      chk("basic_cnt", rd_count, 3);
      chk("basic_n", ng - b, 3);
      chk("basic_reads", rdcnt - r0, 3);
      chk("basic_busy_end", busy, 0);

      // full throughput: 8 contiguous valid cycles
      for (int i = 0; i < 8; i++) push(32'd1 << i);
      b = ng; r0 = rdcnt;
      cyc(2);
      for (int i = 0; i < 8; i++) begin
         chk("thr_valid", m_valid, 1);
         chk("thr_data", m_data, 32'd1 << i);
         cyc(1);
      end
      chk("thr_v_end", m_valid, 0);
      chk("thr_reads", rdcnt - r0, 8);
      chk("thr_cnt", rd_count, 11);

      // backpressure
      en = 1'b0; m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(i + 1);
      b = ng; r0 = rdcnt;
      en = 1'b1;
      cyc(6);
      chk("bp_reads", rdcnt - r0, 2);
      chk("bp_valid", m_valid, 1);
      chk("bp_hold_a", m_data, 1);
      cyc(3);
      chk("bp_hold_b", m_data, 1);
      chk("bp_reads_b", rdcnt - r0, 2);
      for (int i = 0; i < 30; i++) begin
         m_ready = i[0] ? 1'b0 : 1'b1;
         cyc(1);
      end
      m_ready = 1'b1;
      cyc(3);
      chk("bp_n", ng - b, 8);
      for (int i = 0; i < 8; i++) chk("bp_order", got[b + i], i + 1);
      chk("bp_cnt", rd_count, 19);
      chk("bp_reads_all", rdcnt - r0, 8);

      // en deassert after the third read
      en = 1'b0;
      for (int i = 0; i < 8; i++) push(100 + i);
      b = ng; r0 = rdcnt;
      en = 1'b1;
      cyc(3);
      en = 1'b0;
      cyc(8);
      chk("en_reads", rdcnt - r0, 3);
      chk("en_n", ng - b, 3);
      chk("en_idle_v", m_valid, 0);
      chk("en_idle_busy", busy, 0);
      en = 1'b1;
      cyc(14);
      chk("en_reads_all", rdcnt - r0, 8);
      chk("en_n_all", ng - b, 8);
      for (int i = 0; i < 8; i++) chk("en_order", got[b + i], 100 + i);
      chk("en_cnt", rd_count, 27);

      // reset while a word is buffered and another in flight
      en = 1'b0; m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(200 + i);
      en = 1'b1;
      cyc(2);
      chk("mid_valid_pre", m_valid, 1);
      chk("mid_busy_pre", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_valid", m_valid, 0);
      chk("mid_cnt", rd_count, 0);
      chk("mid_busy", busy, 0);
      chk("mid_rden", fifo_rd_en, 0);
      wp = rp;
      cyc(1);
      rst_n = 1'b1;
      r0 = rdcnt;
      cyc(5);
      chk("mid_noreads", rdcnt - r0, 0);
      chk("mid_v_after", m_valid, 0);
      en = 1'b0;

      // counter wrap on a 3-bit instance: 9 reads, 9 handshakes
      en2 = 1'b1;
      cyc(9);
      en2 = 1'b0;
      cyc(5);
      chk("wrap_cnt", cnt2, 1);
      chk("wrap_idle", mv2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side drain engine for the universal synchronous FIFO. It issues cs/rd_en to the FIFO, captures the registered data_out one cycle later, and presents the words in order on a valid/ready stream toward the downstream consumer.
A 2-entry output buffer absorbs the FIFO read latency, so the stream sustains one word per clock while the FIFO is non-empty and the consumer is ready. A wrapping counter tallies delivered words.

Parameters:
DATA_WIDTH, 32, width of FIFO words and stream data
CNT_WIDTH, 16, width of delivered-word counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  enable; when low, no new FIFO reads are issued
fifo_cs  output  1  FIFO chip select; equals en
fifo_rd_en  output  1  FIFO read strobe (combinational from state, fifo_empty and the m_valid/m_ready handshake)
fifo_data_out  input  DATA_WIDTH  FIFO read data, valid the cycle after a rd_en accepted with !empty
fifo_empty  input  1  FIFO empty flag
m_valid  output  1  stream word available
m_data  output  DATA_WIDTH  stream word (head of buffer)
m_ready  input  1  consumer accepts word
rd_count  output  CNT_WIDTH  number of stream handshakes, wraps
busy  output  1  high when the buffer is non-empty or a read is in flight

Behaviour:
- Reset (async, rst_n=0): buffer occupancy=0, inflight=0, rd_count=0, buffer data=0.
  - Outputs: m_valid=0, m_data=0, fifo_rd_en=0, busy=0.
  - fifo_cs follows en even during reset.
  - A read that was in flight at reset is discarded. The FIFO pointer has already advanced, so that word is lost by design.
- State:
  - occ: 0..2 entries, FIFO order, head/tail pointers or shift.
  - inflight: 1 bit.
  - pop = m_valid & m_ready.
- Issue rule: fifo_rd_en = en & !fifo_empty & ((occ+inflight) < 2 | ((occ+inflight)==2 & pop)).
  - Invariant: occ+inflight ≤ 2 after every edge. The buffer never overflows.
- inflight <= fifo_rd_en.
  - When inflight=1, fifo_data_out is written into the buffer tail at that edge.
- Latency:
  - rd_en asserted in cycle t → FIFO registers the word at end of t.
  - Reader captures at end of t+1 → m_valid=1 in cycle t+2.
  - When the buffer is empty, the captured word appears on m_data in t+2 (no bypass path).
- Throughput: with en=1, FIFO continuously non-empty and m_ready=1, fifo_rd_en stays high every cycle and m_valid stays high every cycle from t+2 onward.
- Simultaneous capture and pop: both occur in the same edge and occ is unchanged. The captured word goes behind the remaining entry; order is preserved.
- Backpressure: m_ready=0 with m_valid=1 holds m_data stable until accepted.
  - Reads stop once occ+inflight reaches 2.
- en deassert mid-stream:
  - No new rd_en from that cycle.
  - An inflight word is still captured.
  - The buffer continues draining to the consumer.
  - en does not gate m_valid.
- fifo_empty=1: no rd_en issued. A read issued the previous cycle still completes.
- rd_count increments by 1 on each pop and wraps from 2^CNT_WIDTH-1 to 0.
- m_data is the buffer head register; it holds its last value when m_valid=0.

Test Plan:
- Reset/idle: rst_n=0 mid-operation, with m_valid=1 and inflight=1 → m_valid=0, rd_count=0, busy=0, fifo_rd_en=0 immediately. After release with the FIFO empty, no reads are issued.
- Basic order: FIFO written with 1, 10, 100; en=1, m_ready=1 → m_data sequence 1, 10, 100 on consecutive cycles; first m_valid 2 cycles after first rd_en; rd_count=3; fifo_rd_en low once empty.
- Full throughput: FIFO filled with 8 words 2^0..2^7, m_ready=1 → 8 contiguous m_valid cycles carrying 1, 2, 4 … 128. fifo_rd_en is high for exactly 8 cycles.
- Backpressure: 8 words queued, m_ready=0 → exactly 2 rd_en pulses and m_data=1 held stable. Then release m_ready and toggle it every other cycle → all 8 words delivered in order with no duplicates or drops; rd_count=8.
- en deassert: 8 words queued, drop en after the 3rd rd_en pulse → the 3 words are still delivered and no further reads occur. Re-assert en → remaining 5 delivered in order.
- Counter wrap: CNT_WIDTH=3, 9 words streamed → rd_count reads 1 after the 9th handshake.
